// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the board step controller.
package step_ctrl_pkg;

  localparam int WORD_W    = 8;
  localparam int RUN_SEL_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALT       = 2'd1,
    STEP       = 2'd2,
    RUN        = 2'd3
  } ctrl_state_t;

  // Low 'sel' bits set: a prescaler value matching this mask is a run-rate tick.
  function automatic word_t run_mask(input logic [RUN_SEL_W-1:0] sel);
    word_t m;
    m = '0;
    for (int i = 0; i < WORD_W; i++) begin
      m[i] = (i < int'(sel));
    end
    return m;
  endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// Board-side and CPU-side signal bundle of the step controller.
interface step_ctrl_if;
  import step_ctrl_pkg::*;

  logic [1:0]  keys;
  logic [3:0]  switches;
  word_t       pc;
  logic        cpu_rst;
  logic        cpu_en;
  word_t       step_count;
  ctrl_state_t state;

  modport master (
    output keys, switches, pc,
    input  cpu_rst, cpu_en, step_count, state
  );

  modport slave (
    input  keys, switches, pc,
    output cpu_rst, cpu_en, step_count, state
  );

endinterface

// File: rtl/step_ctrl_key_debounce.sv
// One active-low key: 2-flop synchronizer, stability-count debounce and a
// single-cycle pulse on an accepted press.
module step_ctrl_key_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam logic [15:0] C_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_acc_n;
  logic        r_press;
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_acc_n <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_acc_n) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_acc_n <= r_sync2;
        r_cnt   <= '0;
        // Only the released->pressed acceptance produces a pulse.
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign level = ~r_acc_n;
  assign press = r_press;

endmodule

// File: rtl/step_ctrl.sv
// CPU reset / clock-enable controller driven by board keys and switches.
// Optional breakpoint on pc == BRK_ADDR enabled by STEP_CTRL_BREAK_EN.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  RST_CYCLES      = 8'd4
`ifdef STEP_CTRL_BREAK_EN
  ,
  parameter word_t       BRK_ADDR        = 8'hFF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  step_ctrl_if.slave bus
);

  localparam logic [7:0] C_HOLD_LAST = RST_CYCLES - 8'd1;

  logic [1:0]           w_key_press;
  logic [1:0]           w_key_level_unused;
  logic [3:0]           r_sw_sync1;
  logic [3:0]           r_sw_sync2;
  logic                 w_run_sw;
  logic [RUN_SEL_W-1:0] w_sel;
  logic                 w_rate_hit;
  logic                 w_brk_hit;

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic [7:0]  r_hold_cnt;
  word_t       r_prescale;
  word_t       r_step_count;
  logic        w_cpu_rst;
  logic        w_cpu_en;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      step_ctrl_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw_n (bus.keys[gi]),
        .level (w_key_level_unused[gi]),
        .press (w_key_press[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= bus.switches;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  assign w_run_sw   = r_sw_sync2[0];
  assign w_sel      = r_sw_sync2[3:1];
  assign w_rate_hit = ((r_prescale & run_mask(w_sel)) == run_mask(w_sel));

`ifdef STEP_CTRL_BREAK_EN
  assign w_brk_hit = (bus.pc == BRK_ADDR);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.pc;
  assign w_brk_hit   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cpu_rst    = 1'b0;
    w_cpu_en     = 1'b0;
    case (r_state)
      RESET_HOLD: begin
        w_cpu_rst = 1'b1;
        if (r_hold_cnt == 8'd0) begin
          w_state_next = w_run_sw ? RUN : HALT;
        end
      end
      HALT: begin
        if (w_key_press[1]) begin
          w_state_next = STEP;
        end else if (w_run_sw) begin
          w_state_next = RUN;
        end
      end
      STEP: begin
        w_cpu_en     = 1'b1;
        w_state_next = HALT;
      end
      RUN: begin
        // A breakpoint swallows the step it lands on; a later single step runs it.
        w_cpu_en = w_rate_hit & ~w_brk_hit;
        if (!w_run_sw || (w_rate_hit && w_brk_hit)) begin
          w_state_next = HALT;
        end
      end
      default: w_state_next = RESET_HOLD;
    endcase
    if (w_key_press[0]) begin
      w_state_next = RESET_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET_HOLD;
      r_hold_cnt   <= C_HOLD_LAST;
      r_prescale   <= '0;
      r_step_count <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state != RESET_HOLD || w_key_press[0]) begin
        r_hold_cnt <= C_HOLD_LAST;
      end else if (r_hold_cnt != 8'd0) begin
        r_hold_cnt <= r_hold_cnt - 8'd1;
      end

      // Prescaler only counts while staying in RUN, so every RUN entry starts in phase.
      if (r_state == RUN && w_state_next == RUN) begin
        r_prescale <= r_prescale + 8'd1;
      end else begin
        r_prescale <= '0;
      end

      if (w_state_next == RESET_HOLD) begin
        r_step_count <= '0;
      end else if (w_cpu_en) begin
        r_step_count <= r_step_count + 8'd1;
      end
    end
  end

  assign bus.cpu_rst    = w_cpu_rst;
  assign bus.cpu_en     = w_cpu_en;
  assign bus.step_count = r_step_count;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed/randomized bench for step_ctrl: reset hold, debounce, run rates,
// wrap, key0 reset, simultaneous keys and (when enabled) the breakpoint.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  localparam int RST_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_ctrl_if bus ();

  step_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .RST_CYCLES     (8'd3)
`ifdef STEP_CTRL_BREAK_EN
    ,
    .BRK_ADDR       (8'h05)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CPU model: pc simply follows the number of executed steps.
  assign bus.pc = bus.step_count;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: cpu_en pulses overall and since the last cpu_rst cycle.
  int pulses    = 0;
  int since_rst = 0;
  int rst_seen  = 0;

  always @(negedge clk) begin
    if (bus.cpu_rst) begin
      since_rst <= 0;
      rst_seen  <= rst_seen + 1;
    end else if (bus.cpu_en) begin
      since_rst <= since_rst + 1;
      pulses    <= pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input logic idx, input int len);
    bus.keys[idx] = 1'b0;
    tick(len);
    bus.keys[idx] = 1'b1;
    tick(12);
  endtask

  task automatic wait_state(input ctrl_state_t s, input int budget, input string tag);
    int i;
    i = 0;
    while (bus.state !== s && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, 32'(bus.state), 32'(s));
  endtask

  function automatic logic [31:0] model_count();
    return 32'(since_rst & 255);
  endfunction

  initial begin
    int          n;
    int          p0;
    int          r0;
    int          k;
    int          c0;
    logic [2:0]  sel;

    bus.keys     = 2'b11;
    bus.switches = 4'b0000;
    rst          = 1'b1;
    tick(2);
    check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check("rst_step_count", 32'(bus.step_count), 32'd0);
    check("rst_state", 32'(bus.state), 32'(RESET_HOLD));
    rst = 1'b0;

    n = 0;
    while (bus.cpu_rst === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    check("rst_hold_len", 32'(n), 32'(RST_LEN));
    check("post_rst_state", 32'(bus.state), 32'(HALT));
    check("post_rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check("post_rst_count", 32'(bus.step_count), 32'd0);

    // Glitches shorter than the debounce window must never step.
    for (int g = 0; g < 3; g++) begin
      p0 = pulses;
      bus.keys[1] = 1'b0;
      tick($urandom_range(1, 3));
      bus.keys[1] = 1'b1;
      tick(15);
      check("glitch_no_step", 32'(pulses - p0), 32'd0);
    end
    check("glitch_count", 32'(bus.step_count), 32'd0);

    for (int s = 0; s < 3; s++) begin
      p0 = pulses;
      press_key(1'b1, $urandom_range(6, 12));
      check("step_one_pulse", 32'(pulses - p0), 32'd1);
      check("step_count", 32'(bus.step_count), 32'(s + 1));
      check("step_state", 32'(bus.state), 32'(HALT));
    end

    // Run rates: a window of k * 2^sel RUN cycles holds exactly k steps.
    for (int r = 0; r < 5; r++) begin
      sel = (r == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      k   = (r == 0) ? 16 : $urandom_range(2, 4);
      bus.switches = {sel, 1'b1};
      wait_state(RUN, 20, "run_enter");
      tick(3);
      p0 = pulses;
      tick(k << sel);
      $display("run sel=%0d window=%0d pulses=%0d", sel, k << sel, pulses - p0);
      check("run_rate", 32'(pulses - p0), 32'(k));
      check("run_count", 32'(bus.step_count), model_count());
      bus.switches[0] = 1'b0;
      wait_state(HALT, 20, "run_exit");
      p0 = pulses;
      tick(10);
      check("halt_quiet", 32'(pulses - p0), 32'd0);
      check("halt_state", 32'(bus.state), 32'(HALT));
    end

    // Full-speed run for 256 cycles returns step_count to its start value.
    bus.switches = 4'b0001;
    wait_state(RUN, 20, "wrap_enter");
    tick(3);
    c0 = since_rst & 255;
    p0 = pulses;
    tick(256);
    check("wrap_pulses", 32'(pulses - p0), 32'd256);
    check("wrap_count", 32'(bus.step_count), 32'((c0 + 256) & 255));

    // Debounced key0 mid-run.
    bus.keys[0] = 1'b0;
    n = 0;
    while (bus.cpu_rst !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    bus.keys[0] = 1'b1;
    n = 0;
    while (bus.cpu_rst === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    check("key0_hold_len", 32'(n), 32'(RST_LEN));
    check("key0_count", 32'(bus.step_count), 32'd0);
    check("key0_state", 32'(bus.state), 32'(RUN));
    tick(5);
    check("key0_rerun_count", 32'(bus.step_count), model_count());
    bus.switches = 4'b0000;
    wait_state(HALT, 20, "key0_halt");
    tick(15);

    // Both keys in the same cycle: reset wins, no step.
    p0 = pulses;
    r0 = rst_seen;
    bus.keys = 2'b00;
    tick(10);
    bus.keys = 2'b11;
    wait_state(HALT, 30, "both_halt");
    check("both_no_step", 32'(pulses - p0), 32'd0);
    check("both_reset_len", 32'(rst_seen - r0), 32'(RST_LEN));
    check("both_count", 32'(bus.step_count), 32'd0);
    tick(15);

`ifdef STEP_CTRL_BREAK_EN
    bus.switches = 4'b0001;
    wait_state(RUN, 20, "brk_enter");
    wait_state(HALT, 40, "brk_halt");
    bus.switches = 4'b0000;
    tick(6);
    check("brk_state", 32'(bus.state), 32'(HALT));
    check("brk_count", 32'(bus.step_count), 32'd5);
    press_key(1'b1, 8);
    check("brk_step_count", 32'(bus.step_count), 32'd6);
    check("brk_step_state", 32'(bus.state), 32'(HALT));
`else
    bus.switches = 4'b0001;
    wait_state(RUN, 20, "nobrk_enter");
    tick(20);
    check("nobrk_state", 32'(bus.state), 32'(RUN));
    check("nobrk_count", 32'(bus.step_count), model_count());
    bus.switches = 4'b0000;
    wait_state(HALT, 20, "nobrk_halt");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
